// File: rtl/line_byte_serializer.sv
// Buffers wide memory lines in a small FIFO and emits them as OUT_W-bit
// words over a valid/ready handshake, with overflow and fill-level report.
module line_byte_serializer #(
  parameter int LINE_W    = 512,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LINE_W-1:0]        line_i,
  input  logic                     line_valid_i,
  output logic                     line_ready_o,
  output logic [OUT_W-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int N  = LINE_W / OUT_W;
  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] LAST = WW'(N - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state;
  state_t state_n;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [LINE_W-1:0] sh;
  logic [LINE_W-1:0] sh_n;
  logic [WW-1:0]     idx;
  logic [WW-1:0]     idx_n;
  logic              busy_q;
  logic              busy_n;
  logic              ovf_q;
  logic              push;
  logic              drop;
  logic              pop;
  logic              xfer;

  // Fullness is judged on the registered count, so a pop in the same
  // cycle never rescues a push into a full FIFO.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    pop     = 1'b0;
    xfer    = (state == SEND) && ready_i;
    push    = line_valid_i && (count != FULL);
    drop    = line_valid_i && (count == FULL);
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx != LAST) begin
            idx_n = idx + WW'(1);
            sh_n  = MSB_FIRST ? (sh << OUT_W) : (sh >> OUT_W);
          end else if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
    if (pop) begin
      sh_n  = mem[rd_ptr];
      idx_n = '0;
    end
    count_n = count + CW'(push) - CW'(pop);
    busy_n  = (state_n == SEND) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= line_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      idx    <= idx_n;
      count  <= count_n;
      busy_q <= busy_n;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign data_o       = MSB_FIRST ? sh[LINE_W-1 -: OUT_W] : sh[OUT_W-1:0];
  assign valid_o      = (state == SEND);
  assign busy_o       = busy_q;
  assign level_o      = count;
  assign line_ready_o = (count != FULL);
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_line_byte_serializer.sv
// Drives LSB-first and MSB-first serializers with directed and random
// traffic and compares every cycle against a queue-based line/word model.
module tb_line_byte_serializer;

  localparam int LW    = 32;
  localparam int OW    = 8;
  localparam int DEPTH = 4;
  localparam int N     = LW / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] line = '0;
  logic          lv = 1'b0;
  logic          rdy = 1'b0;

  logic          a_lready, a_valid, a_busy, a_ovf;
  logic [OW-1:0] a_data;
  logic [2:0]    a_level;
  logic          b_lready, b_valid, b_busy, b_ovf;
  logic [OW-1:0] b_data;
  logic [2:0]    b_level;

  always #5 clk = ~clk;

  line_byte_serializer #(
    .LINE_W(LW), .OUT_W(OW), .DEPTH(DEPTH), .MSB_FIRST(1'b0)
  ) u_lsb (
    .clk(clk), .rst(rst), .line_i(line), .line_valid_i(lv),
    .line_ready_o(a_lready), .data_o(a_data), .valid_o(a_valid),
    .ready_i(rdy), .busy_o(a_busy), .level_o(a_level),
    .overflow_o(a_ovf)
  );

  line_byte_serializer #(
    .LINE_W(LW), .OUT_W(OW), .DEPTH(DEPTH), .MSB_FIRST(1'b1)
  ) u_msb (
    .clk(clk), .rst(rst), .line_i(line), .line_valid_i(lv),
    .line_ready_o(b_lready), .data_o(b_data), .valid_o(b_valid),
    .ready_i(rdy), .busy_o(b_busy), .level_o(b_level),
    .overflow_o(b_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference: lines waiting in the buffer, and words still owed for the
  // line currently being sent (one word list per word order).
  logic [LW-1:0] fq[$];
  logic [OW-1:0] ql[$];
  logic [OW-1:0] qm[$];
  bit            m_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic model_step();
    bit            hs;
    bit            ld;
    int            pre;
    logic [LW-1:0] ln;
    if (rst) begin
      fq.delete();
      ql.delete();
      qm.delete();
      m_ovf = 1'b0;
      return;
    end
    pre = fq.size();
    hs  = (ql.size() > 0) && rdy;
    ld  = ((ql.size() == 0) || (hs && ql.size() == 1)) && (pre > 0);
    if (hs) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
    if (ld) begin
      ln = fq.pop_front();
      for (int i = 0; i < N; i++) begin
        ql.push_back(ln[i*OW +: OW]);
        qm.push_back(ln[(N-1-i)*OW +: OW]);
      end
    end
    if (lv) begin
      if (pre < DEPTH) fq.push_back(line);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outs();
    check("valid", a_valid, ql.size() > 0);
    if (ql.size() > 0) check("data", a_data, ql[0]);
    check("valid_msb", b_valid, qm.size() > 0);
    if (qm.size() > 0) check("data_msb", b_data, qm[0]);
    check("level", a_level, fq.size());
    check("busy", a_busy, (ql.size() > 0) || (fq.size() > 0));
    check("line_ready", a_lready, fq.size() < DEPTH);
    check("overflow", a_ovf, m_ovf);
    check("level_msb", b_level, fq.size());
  endtask

  task automatic cyc(input bit v, input logic [LW-1:0] l,
                     input bit r, input bit rs);
    lv   = v;
    line = l;
    rdy  = r;
    rst  = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    int hs;
    bit rv;
    bit v;
    bit rs;
    int rp;

    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("rst_data", a_data, 0);
    check("rst_data_msb", b_data, 0);

    // single line, free-flowing sink
    cyc(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
    check("lat_push_valid", a_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("lat_first_valid", a_valid, 1);
    check("first_word", a_data, 8'hAA);
    check("first_word_msb", b_data, 8'hDD);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

    // back-pressure: ready 1,0,0,1,0,0...
    hs = 0;
    cyc(1'b1, 32'h44332211, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rv = (i % 3 == 0);
      if (a_valid && rv) hs++;
      cyc(1'b0, '0, rv, 1'b0);
    end
    check("handshakes", hs, 4);

    // back-to-back lines, zero bubble
    cyc(1'b1, 32'h03020100, 1'b1, 1'b0);
    cyc(1'b1, 32'h07060504, 1'b1, 1'b0);
    cyc(1'b1, 32'h0B0A0908, 1'b1, 1'b0);
    repeat (14) cyc(1'b0, '0, 1'b1, 1'b0);

    // overflow with a stalled sink
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 32'h11111111 * (i + 1), 1'b0, 1'b0);
    check("ovf_level", a_level, 4);
    check("ovf_ready", a_lready, 0);
    check("ovf_flag", a_ovf, 1);
    repeat (30) cyc(1'b0, '0, 1'b1, 1'b0);
    check("ovf_sticky", a_ovf, 1);

    // reset after two of four words
    cyc(1'b1, 32'hCAFEBABE, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("midrst_valid", a_valid, 0);
    check("midrst_level", a_level, 0);
    check("midrst_ovf", a_ovf, 0);
    cyc(1'b1, 32'h5A6B7C8D, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("after_rst_word0", a_data, 8'h8D);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

    // random traffic at three sink/source rates
    for (int seg = 0; seg < 3; seg++) begin
      rp = (seg == 0) ? 3 : (seg == 1) ? 1 : 2;
      for (int i = 0; i < 1000; i++) begin
        v  = ($urandom_range(0, 2) == 0) || (seg == 2 && $urandom_range(0, 1) == 0);
        rv = ($urandom_range(0, 3) < rp);
        rs = ($urandom_range(0, 299) == 0);
        cyc(v, $urandom, rv, rs);
      end
    end
    repeat (40) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
